// File: rtl/sig_slicer_pkg.sv
// Shared constants and state type for the slicer; classifier width thresholds
// are calibrated against these defaults.
package sig_slicer_pkg;

  localparam int unsigned SAMPLE_DW       = 12;
  localparam int unsigned WIN_LOG2_DEF    = 16;
  localparam int unsigned HYST_SHIFT_DEF  = 3;
  localparam int unsigned DEBOUNCE_DEF    = 4;
  localparam int unsigned MIN_AMP_DEF     = 64;

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    PEND_H = 2'd1,
    HIGH   = 2'd2,
    PEND_L = 2'd3
  } slice_state_t;

endpackage

// File: rtl/sig_slicer_if.sv
// Sample stream in, sliced square wave and window statistics out.
interface sig_slicer_if #(
    parameter int unsigned DW = sig_slicer_pkg::SAMPLE_DW
);

    logic                 din_valid;
    logic signed [DW-1:0] din;
    logic                 sigout;
    logic signed [DW:0]   thr;
    logic        [DW:0]   amp;
    logic                 locked;

    modport master (output din_valid, din, input sigout, thr, amp, locked);
    modport slave  (input din_valid, din, output sigout, thr, amp, locked);

endinterface

// File: rtl/sig_slicer_win_minmax.sv
// Windowed min/max tracker: latches midpoint threshold and peak-to-peak
// amplitude each time 2^WIN_LOG2 valid samples have been seen.
module win_minmax
  import sig_slicer_pkg::*;
#(
    parameter int unsigned DW       = SAMPLE_DW,
    parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din,
    output logic signed [DW:0]   thr,
    output logic        [DW:0]   amp,
    output logic        [DW:0]   close_amp,
    output logic                 win_done,
    output logic                 first_done
);

    logic [WIN_LOG2-1:0] cnt;
    logic                first;
    logic signed [DW:0]  mn, mx, dx, cur_mn, cur_mx, sum;

    // The closing sample participates, so extremes are formed before latching.
    always_comb begin
        dx        = {din[DW-1], din};
        cur_mx    = (first || (dx > mx)) ? dx : mx;
        cur_mn    = (first || (dx < mn)) ? dx : mn;
        sum       = cur_mx + cur_mn;
        close_amp = cur_mx - cur_mn;
        win_done  = din_valid && (cnt == '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            first      <= 1'b1;
            mn         <= '0;
            mx         <= '0;
            thr        <= '0;
            amp        <= '0;
            first_done <= 1'b0;
        end else if (din_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                thr        <= sum >>> 1;
                amp        <= close_amp;
                first      <= 1'b1;
                first_done <= 1'b1;
            end else begin
                mn    <= cur_mn;
                mx    <= cur_mx;
                first <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sig_slicer.sv
// Adaptive hysteresis comparator with consecutive-sample debounce and
// low-amplitude squelch; produces the square wave for the classifier.
module sig_slicer
  import sig_slicer_pkg::*;
#(
    parameter int unsigned DW         = SAMPLE_DW,
    parameter int unsigned WIN_LOG2   = WIN_LOG2_DEF,
    parameter int unsigned HYST_SHIFT = HYST_SHIFT_DEF,
    parameter int unsigned DEBOUNCE   = DEBOUNCE_DEF,
    parameter int unsigned MIN_AMP    = MIN_AMP_DEF
) (
    input logic       clk,
    input logic       rst,
    sig_slicer_if.slave bus
);

    localparam logic [3:0]  DB      = 4'(DEBOUNCE);
    localparam logic [DW:0] MIN_A_W = (DW + 1)'(MIN_AMP);

    slice_state_t        state;
    logic [3:0]          cnt;
    logic                sigout_q;
    logic signed [DW:0]  thr_q, dx, hyst, upper, lower;
    logic        [DW:0]  amp_q, close_amp;
    logic                win_done, first_done, locked, locked_next, above, below;

    win_minmax #(
        .DW       (DW),
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (bus.din_valid),
        .din        (bus.din),
        .thr        (thr_q),
        .amp        (amp_q),
        .close_amp  (close_amp),
        .win_done   (win_done),
        .first_done (first_done)
    );

    // Levels come from the registered window stats, so a closing sample is
    // still judged against the previous window.
    always_comb begin
        dx          = {bus.din[DW-1], bus.din};
        hyst        = $signed(amp_q >> HYST_SHIFT);
        upper       = thr_q + hyst;
        lower       = thr_q - hyst;
        above       = dx > upper;
        below       = dx < lower;
        locked      = first_done && (amp_q >= MIN_A_W);
        locked_next = win_done ? (close_amp >= MIN_A_W) : locked;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOW;
            cnt      <= '0;
            sigout_q <= 1'b0;
        end else if (bus.din_valid) begin
            // Squelched now or squelching on this edge: hold LOW and skip slicing.
            if (!(locked && locked_next)) begin
                state    <= LOW;
                cnt      <= '0;
                sigout_q <= 1'b0;
            end else begin
                unique case (state)
                    LOW: if (above) begin
                        if (DB == 4'd1) begin
                            state    <= HIGH;
                            sigout_q <= 1'b1;
                        end else begin
                            state <= PEND_H;
                            cnt   <= 4'd1;
                        end
                    end
                    PEND_H: if (above) begin
                        if (cnt + 4'd1 == DB) begin
                            state    <= HIGH;
                            cnt      <= '0;
                            sigout_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        state <= LOW;
                        cnt   <= '0;
                    end
                    HIGH: if (below) begin
                        if (DB == 4'd1) begin
                            state    <= LOW;
                            sigout_q <= 1'b0;
                        end else begin
                            state <= PEND_L;
                            cnt   <= 4'd1;
                        end
                    end
                    PEND_L: if (below) begin
                        if (cnt + 4'd1 == DB) begin
                            state    <= LOW;
                            cnt      <= '0;
                            sigout_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        state <= HIGH;
                        cnt   <= '0;
                    end
                    default: begin
                        state <= LOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.sigout = sigout_q;
    assign bus.thr    = thr_q;
    assign bus.amp    = amp_q;
    assign bus.locked = locked;

endmodule

// File: tb/tb_sig_slicer.sv
// Randomised scoreboard bench for sig_slicer with a sample-domain reference model.
module tb_sig_slicer;

    localparam int WIN = 256;
    localparam int DBN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sig_slicer_if bus ();

    sig_slicer #(
        .WIN_LOG2 (8),
        .DEBOUNCE (DBN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sig;
        int thr;
        int amp;
        bit locked;
    } exp_t;

    exp_t exp_q[$];
    exp_t hold;
    int checks   = 0;
    int failures = 0;

    // Reference model state (sample domain)
    int m_win[$];
    int m_thr, m_amp, m_run;
    bit m_locked, m_sig;

    task automatic model_reset();
        m_win.delete();
        m_thr = 0; m_amp = 0; m_run = 0;
        m_locked = 0; m_sig = 0;
    endtask

    task automatic model_step(input int x);
        int up, lo, mx, mn, n_thr, n_amp;
        bit n_locked, qual;
        exp_t e;
        up = m_thr + (m_amp >> 3);
        lo = m_thr - (m_amp >> 3);
        m_win.push_back(x);
        n_thr = m_thr; n_amp = m_amp; n_locked = m_locked;
        if (m_win.size() == WIN) begin
            mx = m_win[0]; mn = m_win[0];
            foreach (m_win[i]) begin
                if (m_win[i] > mx) mx = m_win[i];
                if (m_win[i] < mn) mn = m_win[i];
            end
            n_thr = (mx + mn) >>> 1;
            n_amp = mx - mn;
            n_locked = (n_amp >= 64);
            m_win.delete();
        end
        if (!m_locked || !n_locked) begin
            m_sig = 0; m_run = 0;
        end else begin
            qual = m_sig ? (x < lo) : (x > up);
            m_run = qual ? m_run + 1 : 0;
            if (m_run == DBN) begin
                m_sig = !m_sig;
                m_run = 0;
            end
        end
        m_thr = n_thr; m_amp = n_amp; m_locked = n_locked;
        e.sig = m_sig; e.thr = m_thr; e.amp = m_amp; e.locked = m_locked;
        exp_q.push_back(e);
    endtask

    task automatic compare(input string nm, input exp_t e);
        int a_thr, a_amp;
        a_thr = int'($signed(bus.thr));
        a_amp = int'(bus.amp);
        checks++;
        if (bus.sigout !== e.sig || a_thr != e.thr || a_amp != e.amp || bus.locked !== e.locked) begin
            failures++;
            $display("FAIL %s t=%0t: got sig=%0b thr=%0d amp=%0d locked=%0b, expected sig=%0b thr=%0d amp=%0d locked=%0b",
                     nm, $time, bus.sigout, a_thr, a_amp, bus.locked, e.sig, e.thr, e.amp, e.locked);
        end
    endtask

    // Monitor: checks the response one step after each edge
    logic mv, mr;
    always @(posedge clk) begin
        mv = bus.din_valid;
        mr = rst;
        #1;
        if (mr) begin
            hold = '{sig: 1'b0, thr: 0, amp: 0, locked: 1'b0};
            compare("reset", hold);
        end else if (mv) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL underflow: got a valid sample with no expected entry, required one queued");
            end else begin
                hold = exp_q.pop_front();
                compare("sample", hold);
            end
        end else begin
            compare("hold", hold);
        end
    end

    task automatic send(input int x);
        @(negedge clk);
        bus.din_valid = 1'b1;
        bus.din       = 12'(x);
        model_step(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_valid = 1'b0;
            bus.din       = 12'($urandom_range(0, 4095));
        end
    endtask

    task automatic send_rnd_gap(input int x);
        send(x);
        if ($urandom_range(0, 3) == 0) idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.din_valid = 1'b0;
        model_reset();
        idle(2);
        rst = 1'b0;
    endtask

    function automatic int sq(input int i, input int a, input int noise);
        int n;
        n = (noise > 0) ? int'($urandom_range(0, 2 * noise)) - noise : 0;
        return (((i % 40) < 20) ? a : -a) + n;
    endfunction

    initial begin
        bus.din_valid = 1'b0;
        bus.din       = '0;
        model_reset();
        do_reset();

        // Startup on a flat input, with a reset partway through a window
        for (int i = 0; i < 100; i++) send_rnd_gap(0);
        do_reset();
        for (int i = 0; i < 300; i++) send_rnd_gap(0);

        // Noisy square wave +-1000
        for (int i = 0; i < 700; i++) send_rnd_gap(sq(i, 1000, 30));

        // Glitch bursts, including a sample sitting exactly on the upper level
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 20; i++) send_rnd_gap(-1000);
            send(1000);
            for (int i = 0; i < 10; i++) send(-1000);
            for (int i = 0; i < 3; i++) send(600);
            for (int i = 0; i < 10; i++) send(-1000);
            send(600); send(600); send(250); send(600); send(600); send(600);
            for (int i = 0; i < 10; i++) send(-1000);
            for (int i = 0; i < 4; i++) send(600);
            idle(2);
            for (int i = 0; i < 10; i++) send(-1000);
        end

        // Offset sine: centre +500, peak 800
        for (int i = 0; i < 800; i++)
            send_rnd_gap(500 + int'(800.0 * $sin(6.283185307 * real'(i) / 64.0)));

        // Squelch and recovery
        for (int i = 0; i < 520; i++) send_rnd_gap(sq(i, 20, 0));
        for (int i = 0; i < 600; i++) send_rnd_gap(sq(i, 1000, 0));

        // Sparse valid strobes
        for (int i = 0; i < 560; i++) begin
            send(sq(i, 1000, 10));
            idle(9);
        end

        idle(4);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
